event_serializer: RTL and testbench
===================================

# event_serializer

- Drains 136-bit event words from the sync event FIFO, which sits directly upstream.
- Emits each word as a stream of narrow beats on a valid/ready output toward the chip-level readout interface.
- Pops one FIFO entry per frame and shifts it out MSB-first.
- Sustains back-to-back frames with no idle cycle while the FIFO holds data.
- Optionally appends an XOR checksum beat per frame.

## Interface
Parameters:
- DWIDTH, 136, event word width; must equal the FIFO data width.
- OWIDTH, 8, output beat width; DWIDTH % OWIDTH == 0 is required (elaboration error otherwise).
- CNTW, 16, width of the frame counter.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous assert, active-low; one clock, and reset is asynchronous and active-low.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rdata  in  DWIDTH  FIFO head entry; show-ahead, valid whenever fifo_empty=0.
- fifo_rd_en  out  1  pop strobe to the FIFO.
- out_valid  out  1  out_data holds a valid beat.
- out_ready  in  1  downstream accepts the beat this cycle.
- out_data  out  OWIDTH  current beat.
- out_last  out  1  current beat is the final beat of the frame.
- busy  out  1  a frame is loaded and not yet fully sent.
- frames_sent  out  CNTW  count of fully transmitted frames; wraps modulo 2^CNTW.

## Operation
- NBEATS = DWIDTH/OWIDTH (17 at defaults).
- Frame length FL = NBEATS, or NBEATS+1 with checksum.
- State machine has two states:
  - IDLE: out_valid=0. If fifo_empty=0, assert fifo_rd_en, capture fifo_rdata into the shift register, clear the beat index and checksum accumulator, and go to SEND.
  - SEND: out_valid=1. A beat is accepted on out_valid && out_ready; acceptance advances the beat index and shifts the register left by OWIDTH.
- Leaving SEND, when the last beat of the frame is accepted:
  - frames_sent increments.
  - If fifo_empty=0 in that cycle: fifo_rd_en=1, load the next word, stay in SEND with index 0.
  - Otherwise go to IDLE.
- Payload beat k (k = 0..NBEATS-1) equals bits [DWIDTH-1-k*OWIDTH -: OWIDTH] of the captured word.
- fifo_rd_en is combinational from state, fifo_empty and the accept condition.
  - It never asserts while fifo_empty=1.
  - It never asserts more than once per frame.
- busy = (state == SEND).
- Beat index width is $clog2(FL+1); no overflow is possible.

## Timing
- Reset values: state IDLE; out_valid=0, out_last=0, out_data=0, busy=0, frames_sent=0, fifo_rd_en=0.
- Latency: fifo_empty falls in cycle N → fifo_rd_en=1 in cycle N → first beat has out_valid=1 in N+1.
- With out_ready held high, a frame takes exactly FL cycles. Consecutive frames have zero gap while the FIFO is non-empty.
- Handshake (AXI-Stream rules):
  - While out_valid && !out_ready, out_data, out_last and out_valid hold stable.
  - out_valid never drops without an acceptance.
  - out_ready may be asserted before out_valid and has no effect in IDLE.
- out_last=1 only on beat FL-1 of a frame.
- Simultaneous events:
  - A last-beat accept and a FIFO push of the first entry in the same cycle: the FIFO is still empty in that cycle, so go to IDLE. The new entry is popped next cycle, leaving a one-cycle bubble.
- Reset mid-frame: the frame is dropped without a partial completion. The popped entry is lost; the FIFO is reset by the same rst_n.

## Configuration
- CHECKSUM_EN defined:
  - FL = NBEATS+1.
  - Beat NBEATS carries the XOR of all NBEATS payload beats and has out_last=1.
  - The accumulator is cleared on each load and updated on each accepted payload beat.
- CHECKSUM_EN undefined:
  - FL = NBEATS, with no checksum logic.
  - out_last is set on beat NBEATS-1.

## Test plan
- Single frame, out_ready=1, no checksum:
  - Stimulus: FIFO holds one word with bytes 0x01..0x11, MSB byte 0x01.
  - Required: exactly one fifo_rd_en pulse; out_data 0x01,0x02,…,0x11 on 17 consecutive cycles; out_last only on 0x11; frames_sent=1; then IDLE with out_valid=0.
- Backpressure:
  - Stimulus: same word, out_ready toggled 1,0,0,1,….
  - Required: each byte is held stable while out_ready=0; sequence unchanged; no duplicated or skipped bytes.
- Back-to-back:
  - Stimulus: FIFO preloaded with two words, out_ready=1.
  - Required: 34 consecutive valid beats with no bubble; fifo_rd_en on cycle 0 and on the 17th beat; frames_sent=2.
- CHECKSUM_EN:
  - Stimulus: bytes 0x01..0x11.
  - Required: 18 beats, 18th = 0x01 (XOR of 1..17) with out_last=1.
  - Stimulus: all-0xFF word.
  - Required: checksum 0xFF.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 after beat 5.
  - Required: out_valid=0 and frames_sent=0 immediately (asynchronously); after release, no stale beats appear.
- Empty FIFO:
  - Stimulus: fifo_empty=1 for 100 cycles with out_ready=1.
  - Required: fifo_rd_en never asserts; out_valid stays 0.

Source files
------------

// File: rtl/event_serializer.sv
// Pops 136-bit event words from a show-ahead FIFO and streams them out MSB-first as OWIDTH beats.
// Define CHECKSUM_EN to append an XOR checksum beat to every frame.
module event_serializer #(
    parameter int DWIDTH = 136,
    parameter int OWIDTH = 8,
    parameter int CNTW   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] fifo_rdata,
    output logic              fifo_rd_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OWIDTH-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic [CNTW-1:0]   frames_sent
);

    localparam int NBEATS = DWIDTH / OWIDTH;
`ifdef CHECKSUM_EN
    localparam int FL = NBEATS + 1;
`else
    localparam int FL = NBEATS;
`endif
    localparam int IDXW = $clog2(FL + 1);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(FL - 1);

    generate
        if (DWIDTH % OWIDTH != 0) begin : g_bad_width
            $error("event_serializer: DWIDTH must be a multiple of OWIDTH");
        end
    endgenerate

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state_reg;
    logic [DWIDTH-1:0] shift_reg;
    logic [IDXW-1:0]   idx_reg;
    logic [CNTW-1:0]   frames_reg;
    logic              accept;
    logic              last_beat;
    logic              load;

    assign accept     = (state_reg == SEND) && out_ready;
    assign last_beat  = (idx_reg == LAST_IDX);
    // A pop happens either from IDLE or on the final accept, so at most once per frame.
    assign load       = !fifo_empty && ((state_reg == IDLE) || (accept && last_beat));
    assign fifo_rd_en = load;

    assign out_valid   = (state_reg == SEND);
    assign busy        = (state_reg == SEND);
    assign out_last    = (state_reg == SEND) && last_beat;
    assign frames_sent = frames_reg;

`ifdef CHECKSUM_EN
    logic [OWIDTH-1:0] csum_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_reg <= '0;
        end else if (load) begin
            csum_reg <= '0;
        end else if (accept && !last_beat) begin
            csum_reg <= csum_reg ^ shift_reg[DWIDTH-1 -: OWIDTH];
        end
    end

    assign out_data = last_beat ? csum_reg : shift_reg[DWIDTH-1 -: OWIDTH];
`else
    assign out_data = shift_reg[DWIDTH-1 -: OWIDTH];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            shift_reg  <= '0;
            idx_reg    <= '0;
            frames_reg <= '0;
        end else begin
            if (load) begin
                state_reg <= SEND;
                shift_reg <= fifo_rdata;
                idx_reg   <= '0;
            end else if (accept) begin
                shift_reg <= shift_reg << OWIDTH;
                if (last_beat) begin
                    state_reg <= IDLE;
                end else begin
                    idx_reg <= idx_reg + 1'b1;
                end
            end
            if (accept && last_beat) begin
                frames_reg <= frames_reg + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_event_serializer.sv
// Scoreboard bench for event_serializer: a queue-based FIFO model feeds words, expected beats are queued at push time.
module tb_event_serializer;

    localparam int DWIDTH = 136;
    localparam int OWIDTH = 8;
    localparam int CNTW   = 16;
    localparam int NBEATS = DWIDTH / OWIDTH;
`ifdef CHECKSUM_EN
    localparam int FL = NBEATS + 1;
`else
    localparam int FL = NBEATS;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              fifo_empty = 1'b1;
    logic [DWIDTH-1:0] fifo_rdata = '0;
    logic              fifo_rd_en;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [OWIDTH-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic [CNTW-1:0]   frames_sent;

    event_serializer #(.DWIDTH(DWIDTH), .OWIDTH(OWIDTH), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
        .fifo_rd_en(fifo_rd_en), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy), .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [DWIDTH-1:0] fifo_q[$];
    logic [DWIDTH-1:0] pend_q[$];
    logic [8:0]        exp_q[$];
    logic              pop_pending = 1'b0;

    int rd_cnt = 0, rd_beat = -1, valid_cnt = 0, acc_cnt = 0, beat_cnt = 0, run = 0, max_run = 0;
    logic              hold_pend = 1'b0;
    logic [OWIDTH-1:0] hold_data = '0;
    logic              hold_last = 1'b0;
    logic              bp_mode = 1'b0;
    int                bp_ph = 0;
    int                frames_exp = 0;

    // FIFO model: pops what the DUT strobed at the last edge, then admits newly pushed words.
    always @(posedge clk) begin
        #1;
        if (pop_pending && fifo_q.size() > 0) void'(fifo_q.pop_front());
        while (pend_q.size() > 0) fifo_q.push_back(pend_q.pop_front());
        fifo_empty = (fifo_q.size() == 0);
        fifo_rdata = fifo_empty ? '0 : fifo_q[0];
    end

    always @(posedge clk) begin
        #1;
        if (bp_mode) begin
            out_ready = (bp_ph == 0);
            bp_ph = (bp_ph + 1) % 3;
        end
    end

    // Output monitor: one line per accepted beat, scoreboard compare, handshake stability.
    always @(negedge clk) begin
        if (rst_n) begin
            if (fifo_rd_en) begin
                rd_cnt++;
                if (out_valid) rd_beat = beat_cnt;
                if (fifo_empty) check("rd_en_while_empty", 32'(fifo_rd_en), 32'd0);
            end
            if (hold_pend) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(hold_data));
                check("hold_last", 32'(out_last), 32'(hold_last));
            end
            hold_pend = out_valid && !out_ready;
            hold_data = out_data;
            hold_last = out_last;
            if (out_valid) begin
                valid_cnt++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (out_valid && out_ready) begin
                logic [8:0] e;
                acc_cnt++;
                $display("beat %0d data=%02h last=%0b", beat_cnt, out_data, out_last);
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", 32'(out_data), 32'(e[7:0]));
                    check("beat_last", 32'(out_last), 32'(e[8]));
                end
                beat_cnt = out_last ? 0 : beat_cnt + 1;
            end
        end else begin
            hold_pend = 1'b0;
            run = 0;
        end
        pop_pending = fifo_rd_en && !fifo_empty && rst_n;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_word(input logic [DWIDTH-1:0] w);
        logic [OWIDTH-1:0] b;
        logic [OWIDTH-1:0] cs;
        cs = '0;
        pend_q.push_back(w);
        for (int k = 0; k < NBEATS; k++) begin
            b = w[DWIDTH-1-k*OWIDTH -: OWIDTH];
            cs = cs ^ b;
            exp_q.push_back({(k == FL - 1), b});
        end
`ifdef CHECKSUM_EN
        exp_q.push_back({1'b1, cs});
`endif
        frames_exp++;
    endtask

    task automatic clear_stats();
        rd_cnt = 0; rd_beat = -1; valid_cnt = 0; acc_cnt = 0; run = 0; max_run = 0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        tick();
        while (!(fifo_empty && !busy && pend_q.size() == 0 && exp_q.size() == 0) && n < 500) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, 32'(n >= 500), 32'd0);
    endtask

    function automatic logic [DWIDTH-1:0] ramp_word();
        logic [DWIDTH-1:0] w;
        for (int k = 0; k < NBEATS; k++) w[DWIDTH-1-k*OWIDTH -: OWIDTH] = OWIDTH'(k + 1);
        return w;
    endfunction

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frames", 32'(frames_sent), 32'd0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single frame, ready high
        out_ready = 1'b1;
        clear_stats();
        push_word(ramp_word());
        wait_idle("single");
        check("single_rd_pulses", 32'(rd_cnt), 32'd1);
        check("single_valid_run", 32'(max_run), 32'(FL));
        check("single_frames", 32'(frames_sent), 32'(frames_exp));
        check("single_idle_valid", 32'(out_valid), 32'd0);

        // Backpressure: ready pattern 1,0,0 repeating
        clear_stats();
        bp_ph = 0;
        bp_mode = 1'b1;
        push_word(ramp_word());
        wait_idle("bp");
        bp_mode = 1'b0;
        out_ready = 1'b1;
        check("bp_accepts", 32'(acc_cnt), 32'(FL));
        check("bp_frames", 32'(frames_sent), 32'(frames_exp));

        // Back-to-back: two words preloaded
        tick();
        clear_stats();
        push_word(ramp_word());
        push_word({DWIDTH{1'b1}});
        wait_idle("b2b");
        check("b2b_valid_run", 32'(max_run), 32'(2 * FL));
        check("b2b_rd_pulses", 32'(rd_cnt), 32'd2);
        check("b2b_rd_beat", 32'(rd_beat), 32'(FL - 1));
        check("b2b_frames", 32'(frames_sent), 32'(frames_exp));

        // All-ones word alone
        clear_stats();
        push_word({DWIDTH{1'b1}});
        wait_idle("ones");
        check("ones_frames", 32'(frames_sent), 32'(frames_exp));

        // Reset mid-frame after beat 5
        clear_stats();
        push_word(ramp_word());
        for (int n = 0; n < 100 && acc_cnt < 5; n++) tick();
        check("mid_reached_beat5", 32'(acc_cnt), 32'd5);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_frames", 32'(frames_sent), 32'd0);
        exp_q.delete();
        fifo_q.delete();
        pend_q.delete();
        pop_pending = 1'b0;
        fifo_empty = 1'b1;
        fifo_rdata = '0;
        frames_exp = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        clear_stats();
        repeat (40) tick();
        check("mid_no_stale", 32'(valid_cnt), 32'd0);
        push_word(ramp_word());
        wait_idle("mid_recover");
        check("mid_recover_frames", 32'(frames_sent), 32'(frames_exp));

        // Empty FIFO for 100 cycles
        clear_stats();
        repeat (100) tick();
        check("empty_rd_en", 32'(rd_cnt), 32'd0);
        check("empty_valid", 32'(valid_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
